// File: rtl/gtx_tx_framer.sv
// gtx_tx_framer
// Frames a valid/ready word stream into 8b/10b GTX TX words (txdata/txcharisk).
// Each frame is SOF, FRAME_LEN payload words (PAD fills source stalls), EOF and
// an XOR checksum word. Comma idles are sent between frames so the receiver can
// hold alignment. data_o/ctrl_o are registered: the word visible after an edge
// is the one chosen from the state before that edge.
module gtx_tx_framer #(
  parameter int DATA_BYTES = 2,
  parameter int FRAME_LEN  = 64,
  parameter int MIN_IDLE   = 4
) (
  input  logic                    gt0_txusrclk2,
  input  logic                    gt0_tx_fsm_reset_done,
  input  logic [8*DATA_BYTES-1:0] s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [DATA_BYTES-1:0]   ctrl_o,
  output logic [8*DATA_BYTES-1:0] data_o,
  output logic [7:0]              seq_o
);

  localparam int W   = 8 * DATA_BYTES;
  localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int ICW = (MIN_IDLE > 0) ? $clog2(MIN_IDLE + 1) : 1;

  // txcharisk patterns: only byte 0 ever carries a K-character
  localparam logic [DATA_BYTES-1:0] CTRL_K0 = DATA_BYTES'(1);
  localparam logic [DATA_BYTES-1:0] CTRL_D  = '0;

  // 8b/10b characters
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] D16_2 = 8'h50;

  // Parameter legality is checked at elaboration so a bad build never reaches synthesis
  if (DATA_BYTES != 2 && DATA_BYTES != 4) begin : g_bad_data_bytes
    $error("gtx_tx_framer: DATA_BYTES must be 2 or 4, got %0d", DATA_BYTES);
  end
  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("gtx_tx_framer: FRAME_LEN must be >= 1, got %0d", FRAME_LEN);
  end
  if (MIN_IDLE < 1) begin : g_bad_min_idle
    $error("gtx_tx_framer: MIN_IDLE must be >= 1, got %0d", MIN_IDLE);
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_EOF,
    ST_CHK
  } state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     data_reg, data_next;
  logic [DATA_BYTES-1:0] ctrl_reg, ctrl_next;
  logic [7:0]       seq_reg, seq_next;
  logic [W-1:0]     chk_reg, chk_next;
  logic [WCW-1:0]   word_cnt_reg, word_cnt_next;
  logic [ICW-1:0]   idle_cnt_reg, idle_cnt_next;

  logic [1:0]       rst_sync_reg;
  logic             rst_n_int;

  logic [W-1:0]     idle_word;
  logic [W-1:0]     sof_word;
  logic [W-1:0]     pad_word;
  logic [W-1:0]     eof_word;
  logic             idle_last;
  logic             word_last;
  logic             xfer;

  // Reset asserts immediately and releases on the second edge of gt0_txusrclk2
  always_ff @(posedge gt0_txusrclk2 or negedge gt0_tx_fsm_reset_done) begin
    if (!gt0_tx_fsm_reset_done) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_reg[1];

  // Per-lane construction of the control words; lane 1 carries the sequence number
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
    if (gi == 0) begin : g_byte0
      assign idle_word[gi*8 +: 8] = K28_5;
      assign sof_word [gi*8 +: 8] = K27_7;
      assign pad_word [gi*8 +: 8] = K28_0;
      assign eof_word [gi*8 +: 8] = K29_7;
    end else if (gi == 1) begin : g_byte1
      assign idle_word[gi*8 +: 8] = D16_2;
      assign sof_word [gi*8 +: 8] = seq_reg;
      assign pad_word [gi*8 +: 8] = 8'h00;
      assign eof_word [gi*8 +: 8] = seq_reg;
    end else begin : g_byte_hi
      assign idle_word[gi*8 +: 8] = D16_2;
      assign sof_word [gi*8 +: 8] = 8'h00;
      assign pad_word [gi*8 +: 8] = 8'h00;
      assign eof_word [gi*8 +: 8] = 8'h00;
    end
  end

  // The IDLE word emitted this cycle counts toward the gap, so the gap after CHK
  // is exactly MIN_IDLE words when the source is always ready.
  assign idle_last = (idle_cnt_reg >= ICW'(MIN_IDLE - 1));
  assign word_last = (word_cnt_reg == WCW'(FRAME_LEN - 1));
  assign xfer      = (state_reg == ST_PAYLOAD) && s_valid_i;

  assign s_ready_o = (state_reg == ST_PAYLOAD);
  assign data_o    = data_reg;
  assign ctrl_o    = ctrl_reg;
  assign seq_o     = seq_reg;

  // FSM state register
  always_ff @(posedge gt0_txusrclk2 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output word, checksum, counters and sequence number registers
  always_ff @(posedge gt0_txusrclk2 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      data_reg     <= '0;
      ctrl_reg     <= '0;
      seq_reg      <= '0;
      chk_reg      <= '0;
      word_cnt_reg <= '0;
      idle_cnt_reg <= '0;
    end else begin
      data_reg     <= data_next;
      ctrl_reg     <= ctrl_next;
      seq_reg      <= seq_next;
      chk_reg      <= chk_next;
      word_cnt_reg <= word_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  // Next-state decode and choice of the word to send on the next cycle
  always_comb begin
    state_next    = state_reg;
    data_next     = idle_word;
    ctrl_next     = CTRL_K0;
    seq_next      = seq_reg;
    chk_next      = chk_reg;
    word_cnt_next = word_cnt_reg;
    idle_cnt_next = idle_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        data_next = idle_word;
        ctrl_next = CTRL_K0;
        if (idle_cnt_reg < ICW'(MIN_IDLE)) begin
          idle_cnt_next = idle_cnt_reg + ICW'(1);
        end
        if (idle_last && s_valid_i) begin
          state_next = ST_SOF;
        end
      end

      ST_SOF: begin
        data_next     = sof_word;
        ctrl_next     = CTRL_K0;
        chk_next      = '0;
        word_cnt_next = '0;
        state_next    = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          data_next     = s_data_i;
          ctrl_next     = CTRL_D;
          chk_next      = chk_reg ^ s_data_i;
          word_cnt_next = word_cnt_reg + WCW'(1);
          if (word_last) begin
            state_next = ST_EOF;
          end
        end else begin
          // Source stalled: fill the slot with PAD and wait indefinitely
          data_next = pad_word;
          ctrl_next = CTRL_K0;
        end
      end

      ST_EOF: begin
        data_next  = eof_word;
        ctrl_next  = CTRL_K0;
        state_next = ST_CHK;
      end

      ST_CHK: begin
        data_next     = chk_reg;
        ctrl_next     = CTRL_D;
        seq_next      = seq_reg + 8'd1;
        idle_cnt_next = '0;
        state_next    = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gtx_tx_framer.sv
// Testbench for gtx_tx_framer: a 2-byte and a 4-byte instance (FRAME_LEN=4,
// MIN_IDLE=4) share clock, reset and valid. A vector table covers the single
// frame and stall cases; hand-written sequences cover back-to-back frames,
// sequence wrap and reset in the middle of a payload.
module tb_gtx_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] d2;
  logic [31:0] d4;
  logic        ready2, ready4;
  logic [1:0]  ctrl2;
  logic [3:0]  ctrl4;
  logic [15:0] q2;
  logic [31:0] q4;
  logic [7:0]  seq2, seq4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pay_d = 16'h1357;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic [15:0] exp_data;
    logic [1:0]  exp_ctrl;
    logic [7:0]  exp_seq;
  } vec_t;

  vec_t vecs [28];

  assign d4 = {~d2, d2};

  always #5 clk = ~clk;

  gtx_tx_framer #(.DATA_BYTES(2), .FRAME_LEN(4), .MIN_IDLE(4)) dut2 (
    .gt0_txusrclk2         (clk),
    .gt0_tx_fsm_reset_done (rst_n),
    .s_data_i              (d2),
    .s_valid_i             (valid),
    .s_ready_o             (ready2),
    .ctrl_o                (ctrl2),
    .data_o                (q2),
    .seq_o                 (seq2)
  );

  gtx_tx_framer #(.DATA_BYTES(4), .FRAME_LEN(4), .MIN_IDLE(4)) dut4 (
    .gt0_txusrclk2         (clk),
    .gt0_tx_fsm_reset_done (rst_n),
    .s_data_i              (d4),
    .s_valid_i             (valid),
    .s_ready_o             (ready4),
    .ctrl_o                (ctrl4),
    .data_o                (q4),
    .seq_o                 (seq4)
  );

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic [15:0] ed, input logic [1:0] ec, input logic [7:0] es);
    vec_t t;
    t.valid     = v;
    t.data      = d;
    t.exp_ready = r;
    t.exp_data  = ed;
    t.exp_ctrl  = ec;
    t.exp_seq   = es;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and return just after the following active edge
  task automatic step(input logic v, input logic [15:0] d);
    @(negedge clk);
    valid = v;
    d2    = d;
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 2-byte instance, checking {seq, ctrl, data}
  task automatic step_chk(input string name, input logic v, input logic [15:0] d,
                          input logic [25:0] exp);
    step(v, d);
    check(name, 64'({seq2, ctrl2, q2}), 64'(exp));
  endtask

  // After reset release, wait (bounded) for the first non-zero word
  task automatic wait_first(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (q2 !== 16'h0000) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: data_o still 0000 after 8 cycles, expected 50BC", name);
    end
  endtask

  // One full frame with valid held high: nidle IDLE words, SOF, 4 payload, EOF, CHK
  task automatic frame(input int nidle, input logic [7:0] sq, input string tag);
    logic [15:0] chkm;
    logic [7:0]  sq1;
    chkm = 16'h0000;
    sq1  = sq + 8'd1;
    for (int i = 0; i < nidle; i++)
      step_chk({tag, "_idle"}, 1'b1, 16'hBAD0, {sq, 2'b01, 16'h50BC});
    step_chk({tag, "_sof"}, 1'b1, 16'hBAD1, {sq, 2'b01, sq, 8'hFB});
    for (int k = 0; k < 4; k++) begin
      step_chk({tag, "_payload"}, 1'b1, pay_d, {sq, 2'b00, pay_d});
      chkm  = chkm ^ pay_d;
      pay_d = pay_d + 16'h0F0F;
    end
    step_chk({tag, "_eof"}, 1'b1, 16'hBAD2, {sq, 2'b01, sq, 8'hFD});
    step_chk({tag, "_chk"}, 1'b1, 16'hBAD3, {sq1, 2'b00, chkm});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: still running at %0t, limit 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  sq;
    logic [31:0] w4, chk4;
    logic [15:0] dd;

    // T2/T3 vector table: {valid, data, ready before edge, data/ctrl/seq after edge}
    for (int i = 0; i < 4; i++) vecs[i] = mk(1'b0, 16'h0000, 1'b0, 16'h50BC, 2'b01, 8'd0);
    vecs[4]  = mk(1'b1, 16'h1111, 1'b0, 16'h50BC, 2'b01, 8'd0);
    vecs[5]  = mk(1'b1, 16'h1111, 1'b0, 16'h00FB, 2'b01, 8'd0);
    vecs[6]  = mk(1'b1, 16'h1111, 1'b1, 16'h1111, 2'b00, 8'd0);
    vecs[7]  = mk(1'b1, 16'h2222, 1'b1, 16'h2222, 2'b00, 8'd0);
    vecs[8]  = mk(1'b1, 16'h3333, 1'b1, 16'h3333, 2'b00, 8'd0);
    vecs[9]  = mk(1'b1, 16'h4444, 1'b1, 16'h4444, 2'b00, 8'd0);
    vecs[10] = mk(1'b0, 16'hDEAD, 1'b0, 16'h00FD, 2'b01, 8'd0);
    vecs[11] = mk(1'b0, 16'hDEAD, 1'b0, 16'h4444, 2'b00, 8'd1);
    for (int i = 12; i < 16; i++) vecs[i] = mk(1'b0, 16'hDEAD, 1'b0, 16'h50BC, 2'b01, 8'd1);
    vecs[16] = mk(1'b1, 16'h1111, 1'b0, 16'h50BC, 2'b01, 8'd1);
    vecs[17] = mk(1'b1, 16'h1111, 1'b0, 16'h01FB, 2'b01, 8'd1);
    vecs[18] = mk(1'b1, 16'h1111, 1'b1, 16'h1111, 2'b00, 8'd1);
    vecs[19] = mk(1'b1, 16'h2222, 1'b1, 16'h2222, 2'b00, 8'd1);
    for (int i = 20; i < 23; i++) vecs[i] = mk(1'b0, 16'hDEAD, 1'b1, 16'h001C, 2'b01, 8'd1);
    vecs[23] = mk(1'b1, 16'h3333, 1'b1, 16'h3333, 2'b00, 8'd1);
    vecs[24] = mk(1'b1, 16'h4444, 1'b1, 16'h4444, 2'b00, 8'd1);
    vecs[25] = mk(1'b0, 16'h0000, 1'b0, 16'h01FD, 2'b01, 8'd1);
    vecs[26] = mk(1'b0, 16'h0000, 1'b0, 16'h4444, 2'b00, 8'd2);
    vecs[27] = mk(1'b0, 16'h0000, 1'b0, 16'h50BC, 2'b01, 8'd2);

    // T1: reset held 10 cycles, released with valid low
    rst_n = 1'b0;
    valid = 1'b0;
    d2    = 16'h0000;
    repeat (10) @(posedge clk);
    #1;
    check("t1_rst_data2", 64'(q2), 64'h0);
    check("t1_rst_ctrl2", 64'(ctrl2), 64'h0);
    check("t1_rst_ready2", 64'(ready2), 64'h0);
    check("t1_rst_seq2", 64'(seq2), 64'h0);
    check("t1_rst_word4", 64'({ctrl4, q4}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_first("t1_release");
    check("t1_idle2", 64'({ctrl2, q2}), 64'({2'b01, 16'h50BC}));
    check("t1_idle4", 64'({ctrl4, q4}), 64'({4'b0001, 32'h505050BC}));
    check("t1_ready2", 64'(ready2), 64'h0);

    // T2 single frame and T3 stalled frame, from the table
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      valid = vecs[i].valid;
      d2    = vecs[i].data;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(ready2), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_data", i), 64'(q2), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_ctrl", i), 64'(ctrl2), 64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_seq", i), 64'(seq2), 64'(vecs[i].exp_seq));
    end

    // T4: saturate the idle gap, then three back-to-back frames with valid held high
    for (int i = 0; i < 4; i++)
      step_chk("t4_pre_idle", 1'b0, 16'h0000, {8'd2, 2'b01, 16'h50BC});
    frame(1, 8'd2, "t4_f0");
    frame(4, 8'd3, "t4_f1");
    frame(4, 8'd4, "t4_f2");

    // T5: 257 more frames; the sequence number crosses 255 -> 0
    sq = 8'd5;
    for (int f = 0; f < 257; f++) begin
      frame(4, sq, "t5");
      sq = sq + 8'd1;
    end

    // T6: reset in the middle of a payload
    for (int i = 0; i < 6; i++) step(1'b1, 16'h2468);
    @(negedge clk);
    #1;
    check("t6_ready_mid", 64'(ready2), 64'h1);
    rst_n = 1'b0;
    #1;
    check("t6_async_word2", 64'({seq2, ctrl2, q2}), 64'h0);
    check("t6_async_ready2", 64'(ready2), 64'h0);
    check("t6_async_word4", 64'({seq4, ctrl4, q4}), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_hold_word2", 64'({ctrl2, q2}), 64'h0);
    check("t6_hold_word4", 64'({ctrl4, q4}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    d2    = 16'hBAD4;
    wait_first("t6_release");
    check("t6_first_idle4", 64'({seq4, ctrl4, q4}), 64'({8'd0, 4'b0001, 32'h505050BC}));
    check("t6_first_idle2", 64'({seq2, ctrl2, q2}), 64'({8'd0, 2'b01, 16'h50BC}));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'hBAD5);
      check("t6_idle4", 64'({ctrl4, q4}), 64'({4'b0001, 32'h505050BC}));
      check("t6_idle2", 64'({ctrl2, q2}), 64'({2'b01, 16'h50BC}));
    end
    step(1'b1, 16'hBAD6);
    check("t6_sof4", 64'({seq4, ctrl4, q4}), 64'({8'd0, 4'b0001, 32'h000000FB}));
    check("t6_sof2", 64'({seq2, ctrl2, q2}), 64'({8'd0, 2'b01, 16'h00FB}));
    chk4 = 32'h0;
    dd   = 16'h0102;
    for (int k = 0; k < 4; k++) begin
      w4 = {~dd, dd};
      step(1'b1, dd);
      check("t6_payload4", 64'({ctrl4, q4}), 64'({4'b0000, w4}));
      chk4 = chk4 ^ w4;
      dd   = dd + 16'h1357;
    end
    step(1'b0, 16'h0000);
    check("t6_eof4", 64'({seq4, ctrl4, q4}), 64'({8'd0, 4'b0001, 32'h000000FD}));
    step(1'b0, 16'h0000);
    check("t6_chk4", 64'({seq4, ctrl4, q4}), 64'({8'd1, 4'b0000, chk4}));
    step(1'b0, 16'h0000);
    check("t6_after4", 64'({seq4, ctrl4, q4}), 64'({8'd1, 4'b0001, 32'h505050BC}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
